rom_playback_ctrl: RTL and testbench
====================================

# rom_playback_ctrl

Sequencer that drives the synchronous read port of the waveform ROM (1-cycle read latency, read-enable gated) to play back a programmable address window. On each sample tick it issues one ROM read, re-times the returned word, and presents it downstream as a valid-qualified sample stream. It supports single-shot and looping playback, abort, and a loop counter. It sits between the sample-rate tick generator and the DAC/ADC-stimulus datapath.

## Interface
- `WIDTH`, 8, ROM word width
- `DEPTH`, 1024, ROM depth in words; `AW = $clog2(DEPTH)`
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin playback (sampled in IDLE only)
- `stop`  in  1  abort playback (sampled in RUN only)
- `loop_en`  in  1  1 = loop window forever, 0 = single shot (latched on start)
- `addr_first`  in  AW  first window address (latched on start)
- `addr_last`  in  AW  last window address (latched on start)
- `tick`  in  1  sample-rate enable, one read per high cycle
- `rom_ren`  out  1  ROM read enable
- `rom_addr`  out  AW  ROM address
- `rom_dout`  in  WIDTH  ROM data, valid the cycle after `rom_ren`
- `sample_out`  out  WIDTH  registered sample
- `sample_valid`  out  1  `sample_out` valid, 1-cycle pulse per sample
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  1-cycle pulse on return to IDLE
- `loop_cnt`  out  16  completed window passes, saturating

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - On `start`, latch `loop_en`, `addr_first` and `addr_last`; set `cur = addr_first`; clear `loop_cnt`; go to RUN.
  - `stop` and `tick` are ignored.
- Address clamp: a latched address >= DEPTH is replaced by DEPTH-1.
- RUN, `tick`=1 and `stop`=0:
  - Register `rom_ren=1` and `rom_addr=cur`.
  - Advance `cur`: `cur+1`, wrapping from DEPTH-1 to 0.
  - If `addr_last < addr_first`, the window spans the wrap point.
  - When the read just issued was at `addr_last`:
    - `loop_en`=1: `cur = addr_first`, `loop_cnt` increments (holds at 0xFFFF), stay in RUN.
    - `loop_en`=0: go to DRAIN.
- `addr_first == addr_last`: the window is one word long.
- RUN, `stop`=1: no read is issued, even if `tick`=1. Go to DRAIN.
- RUN, `tick`=0: `rom_ren`=0, `cur` holds.
- DRAIN:
  - No new reads are issued.
  - Stay until no read is in flight, i.e. `rom_ren` and its 1-cycle delayed copy are both 0.
  - Then pulse `done` and go to IDLE.
- Read pipeline: `ren_d <= rom_ren`. When `ren_d`=1, `sample_out <= rom_dout` and `sample_valid <= 1`; otherwise `sample_valid <= 0` and `sample_out` holds.
- Inputs are not re-sampled during RUN or DRAIN, except `tick` and `stop`. `start` is ignored outside IDLE.

## Timing
- Reset (async assert, any state): state goes to IDLE. `rom_ren`, `rom_addr`, `sample_out`, `sample_valid`, `busy`, `done`, `loop_cnt` and `ren_d` all go to 0. Any in-flight sample is discarded.
- `start` high at edge E: `busy`=1 from E+1.
- Latency: `tick` sampled at edge T gives `rom_ren` high in cycle T..T+1. The ROM registers at T+1, so `rom_dout` is valid in T+1..T+2. `sample_valid` is high in cycle T+2..T+3, i.e. 3 edges after the tick.
- `tick` high every cycle gives one sample per cycle; no bubbles, including across loop wrap.
- Single shot, last read at edge T: DRAIN is entered at T. `done` pulses in the same cycle as the final `sample_valid`. State is IDLE and `busy`=0 from T+3.
- Stop at edge S with the last read at S-1: `done` follows the final `sample_valid`. Stop with no read in flight: `done` at S+1 (one DRAIN cycle).
- `loop_cnt` updates on the same edge that issues the `addr_last` read.

## Test plan
- Single shot, first=0, last=3, `tick` every cycle, ROM[i]=i+0x10: `rom_addr` sequence is 0,1,2,3; `sample_out` is 0x10..0x13 on four consecutive valid cycles; `done` pulses once alongside 0x13; `loop_cnt`=0.
- Loop, first=5, last=6, ten ticks: addresses are 5,6,5,6,…; `loop_cnt`=5 after the tenth read; `busy` stays 1.
- Wrap window, DEPTH=1024, first=1022, last=1, single shot: addresses are 1022,1023,0,1; then `done`.
- Sparse ticks (one every 4 cycles), first=0, last=2: exactly one `rom_ren` per tick; each `sample_valid` comes 3 edges after its tick; `cur` holds between ticks.
- `stop` and `tick` high together mid-run at addr 7: no read of 7; pending sample(s) still emitted; then `done`; a following `start` is accepted.
- `rst_n` low while reads are in flight in RUN: all outputs 0 immediately; no `sample_valid` or `done` after release; IDLE.

Source files
------------

// File: rtl/rom_playback_ctrl_if.sv
// rom_playback_ctrl_if
//   Synchronous read port of the waveform ROM.
//   master : sequencer side (drives rom_ren / rom_addr, receives rom_dout)
//   slave  : ROM side (receives rom_ren / rom_addr, drives rom_dout)
//   Signals:
//     rom_ren   read enable
//     rom_addr  read address
//     rom_dout  read data, valid the cycle after rom_ren
interface rom_playback_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 10
);
    logic             rom_ren;
    logic [AW-1:0]    rom_addr;
    logic [WIDTH-1:0] rom_dout;

    modport master (output rom_ren, output rom_addr, input rom_dout);
    modport slave  (input rom_ren, input rom_addr, output rom_dout);
endinterface

// File: rtl/rom_playback_ctrl.sv
// rom_playback_ctrl
//   Plays back an address window of the waveform ROM, one read per sample
//   tick, and re-times the returned words into a valid-qualified stream.
//   Supports single-shot / looping playback, abort and a saturating
//   pass counter.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     start, stop           begin (IDLE only) / abort (RUN only)
//     loop_en               loop forever vs. single shot, latched on start
//     addr_first/addr_last  window bounds, latched on start
//     tick                  sample-rate enable
//     rom                   ROM read port (master side)
//     sample_out/valid      registered sample stream
//     busy, done            activity flag, end-of-playback pulse
//     loop_cnt              completed window passes, saturating
module rom_playback_ctrl #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [AW-1:0]        addr_first,
    input  logic [AW-1:0]        addr_last,
    input  logic                 tick,
    rom_playback_ctrl_if.master  rom,
    output logic [WIDTH-1:0]     sample_out,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          loop_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q, state_nxt;
    logic          ren_q, ren_nxt;
    logic          ren_dly_q;
    logic [AW-1:0] addr_q, addr_nxt;
    logic [AW-1:0] cur_q, cur_nxt;
    logic [AW-1:0] first_q, first_nxt;
    logic [AW-1:0] last_q, last_nxt;
    logic          loop_q, loop_nxt;
    logic [15:0]   cnt_q, cnt_nxt;

    // Only matters for non-power-of-two DEPTH where AW can encode
    // addresses beyond the ROM.
    function automatic logic [AW-1:0] clamp(input logic [AW-1:0] a);
        if (32'(a) >= DEPTH) return AW'(DEPTH - 1);
        return a;
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        if (a == AW'(DEPTH - 1)) return '0;
        return a + AW'(1);
    endfunction

    always_comb begin
        state_nxt = state_q;
        ren_nxt   = 1'b0;
        addr_nxt  = addr_q;
        cur_nxt   = cur_q;
        first_nxt = first_q;
        last_nxt  = last_q;
        loop_nxt  = loop_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    loop_nxt  = loop_en;
                    first_nxt = clamp(addr_first);
                    last_nxt  = clamp(addr_last);
                    cur_nxt   = clamp(addr_first);
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = DRAIN;
                end else if (tick) begin
                    ren_nxt  = 1'b1;
                    addr_nxt = cur_q;
                    // Equality on the wrapped cursor covers windows that
                    // span the DEPTH-1 -> 0 wrap as well as one-word windows.
                    if (cur_q == last_q) begin
                        if (loop_q) begin
                            cur_nxt = first_q;
                            if (cnt_q != '1) cnt_nxt = cnt_q + 16'd1;
                        end else begin
                            state_nxt = DRAIN;
                        end
                    end else begin
                        cur_nxt = next_addr(cur_q);
                    end
                end
            end
            DRAIN: begin
                if (!ren_q && !ren_dly_q) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ren_q        <= 1'b0;
            ren_dly_q    <= 1'b0;
            addr_q       <= '0;
            cur_q        <= '0;
            first_q      <= '0;
            last_q       <= '0;
            loop_q       <= 1'b0;
            cnt_q        <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            ren_q        <= ren_nxt;
            ren_dly_q    <= ren_q;
            addr_q       <= addr_nxt;
            cur_q        <= cur_nxt;
            first_q      <= first_nxt;
            last_q       <= last_nxt;
            loop_q       <= loop_nxt;
            cnt_q        <= cnt_nxt;
            sample_valid <= ren_dly_q;
            if (ren_dly_q) sample_out <= rom.rom_dout;
        end
    end

    assign rom.rom_ren  = ren_q;
    assign rom.rom_addr = addr_q;
    assign busy         = (state_q != IDLE);
    // Last DRAIN cycle: coincides with the final sample_valid, if any.
    assign done         = (state_q == DRAIN) && !ren_q && !ren_dly_q;
    assign loop_cnt     = cnt_q;

endmodule

// File: tb/tb_rom_playback_ctrl.sv
// tb_rom_playback_ctrl
//   Directed bench for rom_playback_ctrl with a behavioural 1-cycle ROM
//   holding ROM[i] = (i + 0x10) mod 256.
module tb_rom_playback_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop, loop_en, tick;
    logic [AW-1:0]    addr_first, addr_last;
    logic [WIDTH-1:0] sample_out;
    logic             sample_valid, busy, done;
    logic [15:0]      loop_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    rom_playback_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) rif ();

    rom_playback_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .addr_first   (addr_first),
        .addr_last    (addr_last),
        .tick         (tick),
        .rom          (rif.master),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done),
        .loop_cnt     (loop_cnt)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] rom_mem [DEPTH];
    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) rom_mem[i] = 8'(i + 16);
        rif.rom_dout = '0;
    end
    always @(posedge clk) if (rif.rom_ren) rif.rom_dout <= rom_mem[rif.rom_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, return 1 time unit after the next rising edge.
    task automatic step(input logic s, input logic p, input logic t);
        @(negedge clk);
        start = s;
        stop  = p;
        tick  = t;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        start;
        logic        tick;
        logic        ren;
        logic [9:0]  addr;
        logic        valid;
        logic [7:0]  sample;
        logic        busy;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt [8];
    logic [7:0] got_q [$];
    int unsigned k;

    initial begin
        // single shot, window 0..3, tick every cycle
        vt[0] = '{1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0};
        vt[1] = '{1'b0, 1'b1, 1'b1, 10'd0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 10'd1, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 10'd2, 1'b1, 8'h10, 1'b1, 1'b0, 16'd0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 10'd3, 1'b1, 8'h11, 1'b1, 1'b0, 16'd0};
        vt[5] = '{1'b0, 1'b1, 1'b0, 10'd3, 1'b1, 8'h12, 1'b1, 1'b0, 16'd0};
        vt[6] = '{1'b0, 1'b1, 1'b0, 10'd3, 1'b1, 8'h13, 1'b1, 1'b1, 16'd0};
        vt[7] = '{1'b0, 1'b1, 1'b0, 10'd3, 1'b0, 8'h13, 1'b0, 1'b0, 16'd0};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0; loop_en = 1'b0;
        addr_first = '0; addr_last = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {rif.rom_ren, rif.rom_addr, sample_out, sample_valid, busy, done, loop_cnt}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // table: single shot
        addr_first = 10'd0; addr_last = 10'd3; loop_en = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            step(vt[i].start, 1'b0, vt[i].tick);
            chk($sformatf("single_v%0d", i),
                {rif.rom_ren, rif.rom_addr, sample_valid, sample_out, busy, done, loop_cnt},
                {vt[i].ren, vt[i].addr, vt[i].valid, vt[i].sample, vt[i].busy, vt[i].done, vt[i].cnt});
        end

        // looping window 5..6, ten ticks
        addr_first = 10'd5; addr_last = 10'd6; loop_en = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("loop_read", {rif.rom_ren, rif.rom_addr}, {1'b1, ((i % 2) != 0) ? 10'd6 : 10'd5});
            chk("loop_cnt", loop_cnt, 64'((i + 1) / 2));
        end
        chk("loop_busy", busy, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        k = 0;
        while (!done && k < 8) begin step(1'b0, 1'b0, 1'b0); k++; end
        chk("loop_stop_done", done, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("loop_idle", busy, 1'b0);

        // wrapping window 1022..1, single shot
        addr_first = 10'd1022; addr_last = 10'd1; loop_en = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        got_q.delete();
        for (int unsigned i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("wrap_addr", {rif.rom_ren, rif.rom_addr}, {1'b1, 10'((1022 + i) % 1024)});
            if (sample_valid) got_q.push_back(sample_out);
        end
        k = 0;
        while (!done && k < 8) begin
            step(1'b0, 1'b0, 1'b1);
            chk("wrap_no_read", rif.rom_ren, 1'b0);
            if (sample_valid) got_q.push_back(sample_out);
            k++;
        end
        chk("wrap_done", done, 1'b1);
        chk("wrap_nsamples", got_q.size(), 4);
        if (got_q.size() == 4)
            chk("wrap_samples", {got_q[0], got_q[1], got_q[2], got_q[3]}, 32'h0E0F1011);
        step(1'b0, 1'b0, 1'b0);
        chk("wrap_idle", busy, 1'b0);

        // sparse ticks, one every 4 cycles, window 0..2
        addr_first = 10'd0; addr_last = 10'd2;
        step(1'b1, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("sparse_read", {rif.rom_ren, rif.rom_addr}, {1'b1, 10'(i)});
            step(1'b0, 1'b0, 1'b0);
            chk("sparse_t1", {rif.rom_ren, sample_valid}, 2'b00);
            step(1'b0, 1'b0, 1'b0);
            chk("sparse_t2", {rif.rom_ren, sample_valid, sample_out, done}, {1'b0, 1'b1, 8'(16 + i), (i == 2)});
            step(1'b0, 1'b0, 1'b0);
            chk("sparse_t3", {rif.rom_ren, sample_valid, busy}, {1'b0, 1'b0, (i != 2)});
        end

        // stop together with tick while cur = 7
        addr_first = 10'd4; addr_last = 10'd20;
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("stop_edge", {rif.rom_ren, sample_valid, sample_out, busy, done}, {1'b0, 1'b1, 8'h15, 1'b1, 1'b0});
        step(1'b0, 1'b0, 1'b1);
        chk("stop_last", {rif.rom_ren, sample_valid, sample_out, done}, {1'b0, 1'b1, 8'h16, 1'b1});
        step(1'b0, 1'b0, 1'b0);
        chk("stop_idle", {busy, sample_valid, done}, 3'b000);

        // restart after stop, one-word window
        addr_first = 10'd9; addr_last = 10'd9;
        step(1'b1, 1'b0, 1'b0);
        chk("restart", {busy, loop_cnt}, {1'b1, 16'd0});
        step(1'b0, 1'b0, 1'b1);
        chk("one_read", {rif.rom_ren, rif.rom_addr}, {1'b1, 10'd9});
        step(1'b0, 1'b0, 1'b1);
        chk("one_t1", {rif.rom_ren, sample_valid, done}, 3'b000);
        step(1'b0, 1'b0, 1'b1);
        chk("one_t2", {sample_valid, sample_out, done}, {1'b1, 8'h19, 1'b1});
        step(1'b0, 1'b0, 1'b0);
        chk("one_idle", busy, 1'b0);

        // stop with nothing in flight: one DRAIN cycle
        addr_first = 10'd0; addr_last = 10'd5;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("stop_empty", {busy, done, sample_valid}, 3'b110);
        step(1'b0, 1'b0, 1'b0);
        chk("stop_empty_idle", {busy, done}, 2'b00);

        // reset while reads are in flight
        addr_first = 10'd0; addr_last = 10'd100;
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {rif.rom_ren, rif.rom_addr, sample_out, sample_valid, busy, done, loop_cnt}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("post_reset", {sample_valid, done, busy, rif.rom_ren}, 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
